// File: rtl/traffic_light_monitor.sv
// Lamp-side supervisor: decodes the controller's lamp outputs into a phase,
// flags illegal combinations, illegal transitions and stuck phases, and counts R->G->Y->R cycles.
module traffic_light_monitor #(
    parameter int MAX_DWELL = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clear_fault,
    output logic [1:0]       phase,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             cycle_done
);

    localparam int DW_W = $clog2(MAX_DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_LIMIT = DW_W'(MAX_DWELL);

    localparam logic [1:0] PH_NONE   = 2'b00;
    localparam logic [1:0] PH_RED    = 2'b01;
    localparam logic [1:0] PH_GREEN  = 2'b10;
    localparam logic [1:0] PH_YELLOW = 2'b11;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_COMBO   = 2'b01;
    localparam logic [1:0] CODE_TRANS   = 2'b10;
    localparam logic [1:0] CODE_STUCK   = 2'b11;

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_e;

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    logic             lampLegal;
    logic [1:0]       samplePhase;
    logic [DW_W-1:0]  dwellInc;
    logic             legalStep;

    always_comb begin
        lampLegal   = $onehot({red, yellow, green});
        samplePhase = PH_NONE;
        if (red)         samplePhase = PH_RED;
        else if (green)  samplePhase = PH_GREEN;
        else if (yellow) samplePhase = PH_YELLOW;
        dwellInc  = dwell_q + DW_W'(1);
        legalStep = (phase_q == PH_RED    && samplePhase == PH_GREEN)  ||
                    (phase_q == PH_GREEN  && samplePhase == PH_YELLOW) ||
                    (phase_q == PH_YELLOW && samplePhase == PH_RED);
    end

    // Control priority: enable low, then clear_fault, then fault detection.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        fault_d = fault_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dwell_d = dwell_q;
        if (!enable) begin
            state_d = IDLE;
            phase_d = PH_NONE;
            fault_d = 1'b0;
            code_d  = CODE_NONE;
            dwell_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    phase_d = PH_NONE;
                    fault_d = 1'b0;
                    code_d  = CODE_NONE;
                    dwell_d = '0;
                end
                SYNC: begin
                    if (lampLegal) begin
                        state_d = TRACK;
                        phase_d = samplePhase;
                        dwell_d = DW_W'(1);
                    end
                end
                TRACK: begin
                    if (clear_fault) begin
                        state_d = SYNC;
                    end else if (!lampLegal) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = CODE_COMBO;
                    end else if (samplePhase == phase_q) begin
                        dwell_d = dwellInc;
                        if (dwellInc == DWELL_LIMIT) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                            code_d  = CODE_STUCK;
                        end
                    end else if (legalStep) begin
                        phase_d = samplePhase;
                        dwell_d = DW_W'(1);
                        if (samplePhase == PH_RED) begin
                            cnt_d  = cnt_q + CNT_W'(1);
                            done_d = 1'b1;
                        end
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = CODE_TRANS;
                    end
                end
                FAULT: begin
                    fault_d = 1'b1;
                    if (clear_fault) begin
                        state_d = SYNC;
                        fault_d = 1'b0;
                        code_d  = CODE_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= PH_NONE;
            fault_q <= 1'b0;
            code_q  <= CODE_NONE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dwell_q <= dwell_d;
        end
    end

    assign phase       = phase_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign cycle_count = cnt_q;
    assign cycle_done  = done_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios followed by
// randomized lamp traffic, all compared against a behavioural model of the monitor rules.
module tb_traffic_light_monitor;

    localparam int MAXD = 4;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          red, yellow, green;
    logic          clear_fault;
    logic [1:0]    phase;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] cycle_count;
    logic          cycle_done;

    traffic_light_monitor #(.MAX_DWELL(MAXD), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .clear_fault (clear_fault),
        .phase       (phase),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count),
        .cycle_done  (cycle_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0=idle 1=sync 2=track 3=fault; phase 1=R 2=G 3=Y.
    int mMode, mPhase, mFault, mCode, mCount, mDone, mDwell;
    int succ [4] = '{0, 2, 3, 1};

    task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mPhase = 0; mFault = 0; mCode = 0; mCount = 0; mDone = 0; mDwell = 0;
    endtask

    task automatic modelRaise(input int code);
        mMode = 3; mFault = 1; mCode = code;
    endtask

    task automatic modelStep(input bit r, input bit y, input bit g, input bit en, input bit clr);
        int lamps, p;
        lamps = int'(r) + int'(y) + int'(g);
        p = r ? 1 : (g ? 2 : (y ? 3 : 0));
        mDone = 0;
        if (!en) begin
            mMode = 0; mPhase = 0; mFault = 0; mCode = 0; mDwell = 0;
        end else if (mMode == 0) begin
            mMode = 1;
        end else if (mMode == 1) begin
            if (lamps == 1) begin
                mMode = 2; mPhase = p; mDwell = 1;
            end
        end else if (mMode == 2) begin
            if (clr) mMode = 1;
            else if (lamps != 1) modelRaise(1);
            else if (p == mPhase) begin
                mDwell++;
                if (mDwell == MAXD) modelRaise(3);
            end else if (p == succ[mPhase]) begin
                mPhase = p; mDwell = 1;
                if (p == 1) begin
                    mCount = (mCount + 1) % (1 << CW);
                    mDone = 1;
                end
            end else modelRaise(2);
        end else begin
            if (clr) begin
                mMode = 1; mFault = 0; mCode = 0;
            end
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".phase"}, phase, mPhase);
        checkOutput({where, ".fault"}, fault, mFault);
        checkOutput({where, ".code"}, fault_code, mCode);
        checkOutput({where, ".count"}, cycle_count, mCount);
        checkOutput({where, ".done"}, cycle_done, mDone);
    endtask

    task automatic applyStimulus(input string where, input bit r, input bit y, input bit g,
                                 input bit en, input bit clr);
        red = r; yellow = y; green = g; enable = en; clear_fault = clr;
        @(posedge clk);
        modelStep(r, y, g, en, clr);
        #1;
        checkAll(where);
    endtask

    task automatic lampPhase(input string where, input int p, input bit en, input bit clr);
        applyStimulus(where, p == 1, p == 3, p == 2, en, clr);
    endtask

    initial begin
        int stimPhase, hold, pick;
        bit en, clr;
        modelReset();
        reset_n = 1'b0; enable = 1'b0; clear_fault = 1'b0;
        red = 1'b0; yellow = 1'b0; green = 1'b0;
        #12;
        checkAll("reset");
        reset_n = 1'b1;
        #1;

        // Normal sequence R x3, G x3, Y x3, R
        lampPhase("idle2sync", 1, 1, 0);
        for (int i = 0; i < 3; i++) lampPhase("normR", 1, 1, 0);
        for (int i = 0; i < 3; i++) lampPhase("normG", 2, 1, 0);
        for (int i = 0; i < 3; i++) lampPhase("normY", 3, 1, 0);
        lampPhase("normR2", 1, 1, 0);
        checkOutput("normal.count1", cycle_count, 1);

        // Illegal combination, sticky, then clear
        applyStimulus("combo", 1, 0, 1, 1, 0);
        lampPhase("comboHold", 2, 1, 0);
        lampPhase("comboHold2", 3, 1, 0);
        lampPhase("comboClear", 1, 1, 1);

        // Illegal transition R->Y, then multi-lamp priority
        lampPhase("transSync", 1, 1, 0);
        lampPhase("transY", 3, 1, 0);
        lampPhase("transClear", 3, 1, 1);
        lampPhase("prioSync", 1, 1, 0);
        applyStimulus("prioMulti", 0, 1, 1, 1, 0);
        lampPhase("prioClear", 2, 1, 1);

        // Stuck green: fault on the 4th identical sample
        for (int i = 0; i < 4; i++) lampPhase("stuckG", 2, 1, 0);
        checkOutput("stuck.code", fault_code, 3);

        // Enable drop in FAULT keeps the count
        lampPhase("enDrop", 2, 0, 0);
        checkOutput("enDrop.count", cycle_count, 1);

        // Five full cycles: count wraps 3->0
        lampPhase("wrapIdle", 1, 1, 0);
        lampPhase("wrapSync", 1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            lampPhase("wrapG", 2, 1, 0);
            lampPhase("wrapY", 3, 1, 0);
            lampPhase("wrapR", 1, 1, 0);
        end

        // Async reset mid-TRACK
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncRst");
        #2 reset_n = 1'b1;

        // Randomized traffic
        stimPhase = 1; hold = 1;
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 59) != 0);
            clr = ($urandom_range(0, 14) == 0);
            pick = $urandom_range(0, 11);
            if (pick == 0) begin
                applyStimulus("rndCombo", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), en, clr);
            end else begin
                if (pick == 1) stimPhase = $urandom_range(1, 3);
                else if (hold == 0) begin
                    stimPhase = succ[stimPhase];
                    hold = $urandom_range(1, MAXD);
                end
                if (hold > 0) hold--;
                lampPhase("rnd", stimPhase, en, clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Lamp-side supervisor for the traffic light controller: it samples the controller's `red`/`yellow`/`green` outputs every clock, decodes the current phase, and checks every lamp sample. It flags illegal lamp combinations, illegal phase transitions and stuck phases, and counts completed R→G→Y→R cycles. It sits alongside the controller on the same clock and feeds the safety/status logic.

## Interface
- `MAX_DWELL`, 16: consecutive samples of one phase that raise a stuck fault; legal range 2..65535.
- `CNT_W`, 8: width of the completed-cycle counter.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  monitoring enable; low forces IDLE.
- `red`, `yellow`, `green`  in  1 each  lamp signals from the controller.
- `clear_fault`  in  1  one-cycle request to leave FAULT.
- `phase`  out  2  decoded phase: 00 none/unknown, 01 RED, 10 GREEN, 11 YELLOW.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  00 none, 01 illegal combination, 10 illegal transition, 11 stuck phase.
- `cycle_count`  out  CNT_W  completed Y→R cycles, wraps modulo 2^CNT_W.
- `cycle_done`  out  1  one-cycle pulse when `cycle_count` increments.

## Operation
- FSM states: IDLE, SYNC, TRACK, FAULT.
- Sample decode: exactly one lamp high gives a legal phase. Zero lamps, or more than one lamp, is an illegal combination.
- IDLE:
  - `phase`=00, `fault`=0, `fault_code`=00, dwell counter cleared.
  - `enable`=1 → SYNC on the next edge.
- SYNC:
  - Waits for the first legal phase sample. Illegal combinations are ignored and raise no fault.
  - On a legal sample: latch the phase, set dwell=1, go to TRACK.
- TRACK, checks on each edge with this priority:
  - (1) Illegal combination → FAULT, code 01.
  - (2) Phase change other than R→G, G→Y or Y→R → FAULT, code 10.
  - (3) Same phase as the previous sample: dwell+1. If the new dwell equals MAX_DWELL → FAULT, code 11.
  - Otherwise a legal change updates `phase` and sets dwell=1.
  - A legal Y→R change also increments `cycle_count` and pulses `cycle_done`.
- FAULT:
  - `fault`=1; `fault_code` holds the first-detected code; `phase` holds its last legal value.
  - `clear_fault`=1 → SYNC, with `fault`=0 and `fault_code`=00.
- `enable`=0 in any state → IDLE on the next edge and clears the fault. `cycle_count` is preserved.
- Priority, highest first: `reset_n` low, then `enable` low, then `clear_fault`, then fault detection.
  - `clear_fault` in TRACK (no fault pending) → SYNC, and that cycle's sample is not checked.
- Dwell counter width: clog2(MAX_DWELL+1); it never wraps.
- `cycle_count` increments only in TRACK, never in SYNC. It wraps from 2^CNT_W−1 to 0, and `cycle_done` still pulses on the wrap.

## Timing
- Reset values: `phase`=00, `fault`=0, `fault_code`=00, `cycle_count`=0, `cycle_done`=0, state IDLE, dwell=0.
- All outputs are registered. Lamp values sampled at edge N are reflected in `phase`/`fault`/`fault_code`/`cycle_count`/`cycle_done` right after edge N (1-cycle latency from input change).
- Stuck fault: raised at the edge sampling the MAX_DWELL-th consecutive identical phase. The first TRACK sample after a legal change counts as sample 1.
- `cycle_done` is high for exactly one cycle per Y→R change; back-to-back pulses are impossible because each phase needs at least one sample.
- Entering TRACK: IDLE→SYNC takes one edge, SYNC→TRACK takes one edge (the first legal sample).
- Asserting `reset_n` mid-FAULT or mid-TRACK clears everything immediately (asynchronously), including `cycle_count`.

## Test plan
- Normal sequence: reset, `enable`=1, lamps R(3 cycles)→G(3)→Y(3)→R, MAX_DWELL=16 → `phase` 01→10→11→01, `cycle_done` one pulse at Y→R, `cycle_count`=1, `fault`=0.
- Illegal combination: in TRACK drive `red`=`green`=1 for one cycle → `fault`=1 and `fault_code`=01 at the next edge. `fault` stays high after the lamps return legal. `clear_fault` pulse → `fault`=0 and state SYNC.
- Illegal transition: R then Y directly → `fault_code`=10. A simultaneous multi-lamp sample yields 01 (priority).
- Stuck: MAX_DWELL=4, hold G → `fault`=1 and code 11 exactly at the 4th consecutive G sample, not the 3rd.
- Wrap: CNT_W=2, run 5 full cycles → `cycle_count` sequence 1,2,3,0,1 with a `cycle_done` pulse on each, including the 3→0 wrap.
- Control priority: `enable` drop while in FAULT → IDLE, `fault`=0, `cycle_count` retained. `reset_n` low mid-TRACK → all outputs 0 within the same cycle, without waiting for a clock edge.
